// File: rtl/ps2_pkg.sv
// ps2_pkg: handshake state encoding and Set-2 prefix codes
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, POP, SETTLE} state_t;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT = 8'hE0;
endpackage

// File: rtl/scancode_to_ascii.sv
// scancode_to_ascii: Set-2 make code to lowercase ASCII for letters, digits, space and enter
module scancode_to_ascii (
  input  logic [7:0] code,
  output logic [7:0] ascii
);
  always_comb begin
    ascii = 8'h00;
    case (code)
      8'h1C: ascii = 8'h61;
      8'h32: ascii = 8'h62;
      8'h21: ascii = 8'h63;
      8'h23: ascii = 8'h64;
      8'h24: ascii = 8'h65;
      8'h2B: ascii = 8'h66;
      8'h34: ascii = 8'h67;
      8'h33: ascii = 8'h68;
      8'h43: ascii = 8'h69;
      8'h3B: ascii = 8'h6A;
      8'h42: ascii = 8'h6B;
      8'h4B: ascii = 8'h6C;
      8'h3A: ascii = 8'h6D;
      8'h31: ascii = 8'h6E;
      8'h44: ascii = 8'h6F;
      8'h4D: ascii = 8'h70;
      8'h15: ascii = 8'h71;
      8'h2D: ascii = 8'h72;
      8'h1B: ascii = 8'h73;
      8'h2C: ascii = 8'h74;
      8'h3C: ascii = 8'h75;
      8'h2A: ascii = 8'h76;
      8'h1D: ascii = 8'h77;
      8'h22: ascii = 8'h78;
      8'h35: ascii = 8'h79;
      8'h1A: ascii = 8'h7A;
      8'h45: ascii = 8'h30;
      8'h16: ascii = 8'h31;
      8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33;
      8'h25: ascii = 8'h34;
      8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36;
      8'h3D: ascii = 8'h37;
      8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h29: ascii = 8'h20;
      8'h5A: ascii = 8'h0D;
      default: ascii = 8'h00;
    endcase
  end
endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: pops ps2_keyboard FIFO bytes and assembles make/break/E0 sequences into key events
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ready,
  input  logic [7:0]       data,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic [7:0]       key_ascii,
  output logic             key_down,
  output logic             key_valid,
  output logic [CNT_W-1:0] press_count,
  output logic             ovf_seen
);
  localparam int SW = SETTLE_CYC > 1 ? $clog2(SETTLE_CYC) : 1;
  state_t state, state_nx;
  logic [SW-1:0] set_cnt;
  logic [7:0] byte_r, ascii_c;
  logic brk_pend, ext_pend, same, settle_done;
  scancode_to_ascii u_lut (.code(byte_r), .ascii(ascii_c));
  assign same = key_down && byte_r == key_code && ext_pend == key_ext;
  assign settle_done = set_cnt == SW'(SETTLE_CYC - 1);
  // pop strobe decodes straight from state so reset releases it on the same edge
  assign nextdata_n = state != POP;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (ready ? POP : IDLE) :
               state == POP ? SETTLE :
               settle_done ? IDLE : SETTLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      set_cnt <= '0;
      byte_r <= 8'h00;
      brk_pend <= 1'b0;
      ext_pend <= 1'b0;
      key_code <= 8'h00;
      key_ext <= 1'b0;
      key_ascii <= 8'h00;
      key_down <= 1'b0;
      key_valid <= 1'b0;
      press_count <= '0;
      ovf_seen <= 1'b0;
    end else begin
      state <= state_nx;
      key_valid <= 1'b0;
      set_cnt <= state == SETTLE ? set_cnt + 1'b1 : '0;
      if (overflow) ovf_seen <= 1'b1;
      if (state == IDLE && ready) byte_r <= data;
      if (state == POP) begin
        if (byte_r == SC_BREAK) brk_pend <= 1'b1;
        else if (byte_r == SC_EXT) ext_pend <= 1'b1;
        else begin
          brk_pend <= 1'b0;
          ext_pend <= 1'b0;
          if (brk_pend) begin
            if (same) key_down <= 1'b0;
          end else if (!same) begin
            key_code <= byte_r;
            key_ext <= ext_pend;
            key_ascii <= ext_pend ? 8'h00 : ascii_c;
            key_down <= 1'b1;
            key_valid <= 1'b1;
            press_count <= press_count + 1'b1;
          end
        end
      end
    end
  end
endmodule
